irq_capture4: RTL and testbench
===============================

# irq_capture4

Request-capture front end for the 4-to-2 priority encoder. It synchronises four asynchronous request lines and detects events per line, in edge or level mode. It holds events as pending bits until acknowledged, applies a per-line mask, and drives the masked pending vector straight into the encoder's `d` input. The encoder's `y` returns as `ack_idx` to retire the serviced request.

## Interface
Parameters:
- `N` — 4 — number of request lines; must equal encoder input width.
- `SYNC_STAGES` — 2 — synchroniser depth, minimum 2.

Ports:
- `clk` — in — 1 — single clock; all state updates on rising edge.
- `rst_n` — in — 1 — reset; synchronous and active-low.
- `irq_in` — in — N — raw asynchronous request lines.
- `mode` — in — N — per line: 1 = rising-edge capture, 0 = level capture. Quasi-static.
- `mask` — in — N — per line: 1 = enabled to `pend`.
- `ack` — in — 1 — single-cycle acknowledge strobe.
- `ack_idx` — in — $clog2(N) — index of the line being acknowledged; connects to encoder `y`.
- `ovf_clr` — in — 1 — clears all overflow flags.
- `pend` — out — N — `raw_pend & mask`; connects to encoder `d`.
- `raw_pend` — out — N — unmasked pending bits.
- `ovf` — out — N — sticky per-line overflow flags.

## Operation
- Each line passes through a SYNC_STAGES flop chain to produce `s[i]`.
- A `prev[i]` register holds the last `s[i]`.
- Edge mode:
  - event = `s[i] & ~prev[i]`.
  - An event sets `raw_pend[i]`.
  - `ack` with `ack_idx==i` clears `raw_pend[i]`.
- Level mode:
  - `raw_pend[i] <= s[i]` every cycle.
  - `ack` has no effect on that line.
  - `ovf[i]` never sets on that line.
- Overflow: in edge mode, an event on a line whose pending bit is already 1 and not being acked this cycle sets `ovf[i]`. The pending bit remains 1; the second event is not counted.
- Masking gates only `pend`. Capture and overflow proceed on masked lines; unmasking exposes stored pending bits immediately.
- An internal `mode_q` register tracks `mode`. A change on line i clears `raw_pend[i]` and `ovf[i]` in that cycle. Software changes mode only while the line is masked.
- `ack_idx >= N` is ignored, and `ack` on a non-pending line has no effect.
- Each line evaluates independently in the same cycle; there is no inter-line arbitration, which belongs to the encoder.

## Timing
- Reset (`rst_n==0` at a rising edge) clears every synchroniser flop, `prev`, `mode_q`, `raw_pend` and `ovf`.
  - `pend`, `raw_pend` and `ovf` read 0 from the first edge with `rst_n` low.
  - `mode_q` resets to all-0 (level); the first post-reset cycle with `mode` bit 1 counts as a mode change, leaving pending and ovf clear.
- Reset mid-operation discards all pending events and overflow state.
  - An edge-mode line held high through reset produces exactly one event after release, because `prev` resets to 0.
- Capture latency: `irq_in[i]` rising, sampled at edge E0, gives `raw_pend[i]` and `pend[i]` high after edge E(SYNC_STAGES). With default 2, that is after E2.
- Ack latency: `ack` sampled at edge E gives the bit low after E, so the encoder sees the next-priority request in cycle E+1.
- Simultaneous events:
  - new edge + ack, same line, same cycle → set wins; bit stays 1; no overflow.
  - overflow set + `ovf_clr`, same cycle → set wins.
  - mode change + event, same line, same cycle → clear wins.
- Outputs are registered, except for the AND with `mask`, which is combinational from the `mask` input.

## Structure
- Shared package `irq_pkg`:
  - `N_IRQ = 4`
  - `IRQ_IDX_W = $clog2(N_IRQ)`
  - localparams `MODE_LEVEL = 1'b0`, `MODE_EDGE = 1'b1`
- One sub-module, `sync_ff`: a parameterised-depth, per-bit-vector synchroniser instantiated once with width N, reset synchronous active-low.
- Top level holds the edge detect, pending, overflow and mode-change logic as per-line generate loops.
- Expected size is about 150–200 lines of RTL.

## Test plan
- Reset release with `mode=4'b1111` and `mask=4'b1111`:
  - With `irq_in=0` → `pend=0` and `ovf=0` for 5 cycles.
  - With `irq_in[2]` high through reset → `pend=4'b0100` two cycles after release.
- Edge capture: `mode=4'b1111`, pulse `irq_in=4'b1010` for 1 cycle (sampled at E0) → `pend=4'b1010` after E2.
  - `ack=1`, `ack_idx=3` at E3 → `pend=4'b0010` after E3.
  - `ack_idx=1` at E4 → `pend=0`.
- Overflow: second pulse on line 0 while `raw_pend[0]=1` and not acked → `ovf=4'b0001`.
  - `ovf_clr` → `ovf=0` next edge.
  - Repeat with `ovf_clr` asserted the same cycle as the overflow → `ovf=4'b0001`, since set wins.
- Edge + ack collision: event on line 1 arrives in the same cycle as `ack_idx=1` → `raw_pend[1]` stays 1 and `ovf[1]` stays 0.
- Level mode: `mode=0`, `irq_in[3]` high for 4 cycles → `raw_pend[3]` high for 4 cycles (delayed 2).
  - `ack_idx=3` during that window → no change.
- Mask: `mask=4'b0000`, edge on line 2 → `pend=0` and `raw_pend=4'b0100`.
  - Setting `mask=4'b0100` → `pend=4'b0100` the same cycle.
  - Toggling `mode[2]` → `raw_pend[2]=0` after the next edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt capture front end and its 4-to-2 priority encoder.
package irq_pkg;

  localparam int unsigned N_IRQ     = 4;
  localparam int unsigned IRQ_IDX_W = $clog2(N_IRQ);

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/irq_capture4_sync_ff.sv
// Multi-stage flop synchroniser for a bit vector; synchronous active-low reset.
module sync_ff #(
  parameter int unsigned W      = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) stg[k] <= '0;
    end else begin
      stg[0] <= d;
      for (int unsigned k = 1; k < STAGES; k++) stg[k] <= stg[k-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/irq_capture4.sv
// Request capture: synchronise, detect edge/level events, hold pending until acked,
// flag overflow, and present the masked pending vector to the priority encoder.
module irq_capture4
  import irq_pkg::*;
#(
  parameter int unsigned N           = N_IRQ,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         irq_in,
  input  logic [N-1:0]         mode,
  input  logic [N-1:0]         mask,
  input  logic                 ack,
  input  logic [$clog2(N)-1:0] ack_idx,
  input  logic                 ovf_clr,
  output logic [N-1:0]         pend,
  output logic [N-1:0]         raw_pend,
  output logic [N-1:0]         ovf
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0] s;
  logic [N-1:0] prev;
  logic [N-1:0] mode_q;
  logic [N-1:0] ev;
  logic [N-1:0] chg;
  logic [N-1:0] hit;
  logic [N-1:0] is_edge;
  logic [N-1:0] ovf_set;
  logic [N-1:0] raw_nxt;
  logic [N-1:0] ovf_nxt;

  sync_ff #(
    .W      (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_in),
    .q     (s)
  );

  // Per-line next state; mode change clears first, then a new edge beats an ack.
  for (genvar i = 0; i < N; i++) begin : g_line
    assign ev[i]      = s[i] & ~prev[i];
    assign chg[i]     = mode[i] ^ mode_q[i];
    assign hit[i]     = ack & (ack_idx == IDX_W'(i));
    assign is_edge[i] = (mode[i] == MODE_EDGE);
    assign ovf_set[i] = is_edge[i] & ev[i] & raw_pend[i] & ~hit[i];

    assign raw_nxt[i] = chg[i]     ? 1'b0 :
                        is_edge[i] ? (ev[i] | (raw_pend[i] & ~hit[i])) :
                                     s[i];

    assign ovf_nxt[i] = chg[i] ? 1'b0 : (ovf_set[i] | (ovf[i] & ~ovf_clr));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev     <= '0;
      mode_q   <= '0;
      raw_pend <= '0;
      ovf      <= '0;
    end else begin
      prev     <= s;
      mode_q   <= mode;
      raw_pend <= raw_nxt;
      ovf      <= ovf_nxt;
    end
  end

  // Only the mask path is combinational so unmasking exposes stored bits at once.
  assign pend = raw_pend & mask;

endmodule

// File: tb/tb_irq_capture4.sv
// Self-checking bench for irq_capture4: vector table, hand sequences and a random
// run compared against a cycle-level reference model of the capture rules.
module tb_irq_capture4;
  import irq_pkg::*;

  localparam int unsigned N    = N_IRQ;
  localparam int unsigned SYNC = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   irq_in, mode, mask;
  logic           ack;
  logic [1:0]     ack_idx;
  logic           ovf_clr;
  logic [N-1:0]   pend, raw_pend, ovf;

  int checks = 0;
  int failures = 0;

  irq_capture4 #(.N(N), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .mode     (mode),
    .mask     (mask),
    .ack      (ack),
    .ack_idx  (ack_idx),
    .ovf_clr  (ovf_clr),
    .pend     (pend),
    .raw_pend (raw_pend),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] m_sh [SYNC];
  logic [N-1:0] m_prev, m_modeq, m_raw, m_ovf;

  typedef struct {
    logic       rst_n;
    logic [3:0] irq;
    logic [3:0] mode;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] idx;
    logic       clr;
    logic [3:0] e_pend;
    logic [3:0] e_raw;
    logic [3:0] e_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic [3:0] i, logic [3:0] md, logic [3:0] mk_,
                              logic a, logic [1:0] ix, logic c,
                              logic [3:0] ep, logic [3:0] er, logic [3:0] eo);
    vec_t v;
    v.rst_n = r; v.irq = i; v.mode = md; v.mask = mk_; v.ack = a; v.idx = ix; v.clr = c;
    v.e_pend = ep; v.e_raw = er; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply the capture rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic [N-1:0] s, nraw, novf;
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) m_sh[k] = '0;
      m_prev = '0; m_modeq = '0; m_raw = '0; m_ovf = '0;
    end else begin
      s = m_sh[SYNC-1];
      for (int i = 0; i < N; i++) begin
        bit changed, event_i, acked;
        changed = (mode[i] != m_modeq[i]);
        event_i = s[i] && !m_prev[i];
        acked   = ack && (int'(ack_idx) == i);
        nraw[i] = m_raw[i];
        novf[i] = ovf_clr ? 1'b0 : m_ovf[i];
        if (changed) begin
          nraw[i] = 1'b0;
          novf[i] = 1'b0;
        end else if (mode[i] == MODE_EDGE) begin
          if (event_i) begin
            if (m_raw[i] && !acked) novf[i] = 1'b1;
            nraw[i] = 1'b1;
          end else if (acked) begin
            nraw[i] = 1'b0;
          end
        end else begin
          nraw[i] = s[i];
        end
      end
      for (int k = SYNC-1; k > 0; k--) m_sh[k] = m_sh[k-1];
      m_sh[0] = irq_in;
      m_prev  = s;
      m_modeq = mode;
      m_raw   = nraw;
      m_ovf   = novf;
    end
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    model_edge();
    #1;
    chk({nm, ".model_pend"}, pend, m_raw & mask);
    chk({nm, ".model_raw"}, raw_pend, m_raw);
    chk({nm, ".model_ovf"}, ovf, m_ovf);
  endtask

  task automatic idle();
    irq_in = '0; ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; mode = 4'b1111; mask = 4'b1111;
    ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
    for (int k = 0; k < SYNC; k++) m_sh[k] = '0;
    m_prev = '0; m_modeq = '0; m_raw = '0; m_ovf = '0;

    // Reset, idle, edge capture + acks, overflow, ovf_clr collision, edge+ack collision
    vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b1010, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b1010, 4'b1010, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 1, 3, 0, 4'b0010, 4'b0010, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b0001, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b0001, 4'b1111, 4'b1111, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0001, 4'b0001, 4'b0001));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 1, 4'b0001, 4'b0001, 4'b0000));
    vq.push_back(mk(1, 4'b0001, 4'b1111, 4'b1111, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 1, 4'b0001, 4'b0001, 4'b0001));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b0010, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vq.push_back(mk(1, 4'b0010, 4'b1111, 4'b1111, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 1, 1, 0, 4'b0010, 4'b0010, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 4'b1111, 4'b1111, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000));

    foreach (vq[r]) begin
      rst_n = vq[r].rst_n; irq_in = vq[r].irq; mode = vq[r].mode; mask = vq[r].mask;
      ack = vq[r].ack; ack_idx = vq[r].idx; ovf_clr = vq[r].clr;
      tick($sformatf("vec%0d", r));
      chk($sformatf("vec%0d.pend", r), pend, vq[r].e_pend);
      chk($sformatf("vec%0d.raw", r), raw_pend, vq[r].e_raw);
      chk($sformatf("vec%0d.ovf", r), ovf, vq[r].e_ovf);
    end
    idle();

    // Level mode: raw follows the line two edges late; ack has no effect
    mode = 4'b0000;
    tick("lvl_chg");
    chk("lvl_chg.raw", raw_pend, 4'b0000);
    tick("lvl_idle");
    for (int c = 0; c < 8; c++) begin
      irq_in = (c < 4) ? 4'b1000 : 4'b0000;
      ack = (c == 3); ack_idx = 2'd3;
      tick($sformatf("lvl%0d", c));
      chk($sformatf("lvl%0d.raw", c), raw_pend, (c >= 2 && c < 6) ? 4'b1000 : 4'b0000);
      chk($sformatf("lvl%0d.ovf", c), ovf, 4'b0000);
    end
    idle();

    // Mask gates only pend; unmasking is immediate; mode toggle clears the line
    mode = 4'b1111; mask = 4'b0000;
    tick("msk_chg");
    tick("msk_idle");
    irq_in = 4'b0100;
    tick("msk_e0");
    irq_in = 4'b0000;
    tick("msk_e1");
    tick("msk_e2");
    chk("msk_e2.pend", pend, 4'b0000);
    chk("msk_e2.raw", raw_pend, 4'b0100);
    mask = 4'b0100;
    #1;
    chk("msk_unmask.pend", pend, 4'b0100);
    mask = 4'b0000; mode = 4'b1011;
    tick("msk_mode");
    chk("msk_mode.raw", raw_pend, 4'b0000);
    mode = 4'b1111; mask = 4'b1111;
    tick("msk_restore");

    // Edge line held high through reset yields exactly one event after release
    irq_in = 4'b0100; rst_n = 1'b0;
    tick("hold_rst0");
    chk("hold_rst0.pend", pend, 4'b0000);
    tick("hold_rst1");
    rst_n = 1'b1;
    tick("hold_r1");
    chk("hold_r1.pend", pend, 4'b0000);
    tick("hold_r2");
    chk("hold_r2.pend", pend, 4'b0000);
    tick("hold_r3");
    chk("hold_r3.pend", pend, 4'b0100);
    ack = 1'b1; ack_idx = 2'd2;
    tick("hold_ack");
    chk("hold_ack.pend", pend, 4'b0000);
    ack = 1'b0;
    tick("hold_r5");
    chk("hold_r5.pend", pend, 4'b0000);
    chk("hold_r5.ovf", ovf, 4'b0000);
    idle();

    // Random run against the model
    for (int c = 0; c < 1500; c++) begin
      irq_in  = irq_in ^ (4'($urandom) & 4'($urandom));
      mask    = 4'($urandom);
      ack     = ($urandom_range(0, 2) == 0);
      ack_idx = 2'($urandom);
      ovf_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) mode = mode ^ (4'b0001 << $urandom_range(0, 3));
      rst_n   = ($urandom_range(0, 149) != 0);
      tick($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
